// File: rtl/oled_text_pkg.sv
// Shared constants and state encoding for the OLED text buffer.
package oled_text_pkg;

  localparam int LINES = 4;
  localparam int COLS = 16;
  localparam int NCHARS = LINES * COLS;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/oled_char_ram.sv
// Character cell store: one write port, one combinational read port.
// Flags every in-range write so the owner knows the screen is stale.
module oled_char_ram
  import oled_text_pkg::*;
#(
  parameter int DEPTH  = NCHARS,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              dirty_set
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]       cells [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx    = wr_addr[IDX_W-1:0];
  assign rd_idx    = rd_addr[IDX_W-1:0];
  assign dirty_set = wr_en && ({1'b0, wr_addr} < LIMIT);
  assign rd_data   = cells[rd_idx];

  // Blank the screen on reset, otherwise store accepted characters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells[i] <= ASCII_SPACE;
      end
    end else if (dirty_set) begin
      cells[wr_idx] <= wr_char;
    end
  end

endmodule

// File: rtl/oled_text_buffer.sv
// Writable character buffer that repaints the whole screen into the
// oled_controller byte handshake whenever contents change or a refresh
// is requested.
module oled_text_buffer
  import oled_text_pkg::*;
#(
  parameter int LINES  = oled_text_pkg::LINES,
  parameter int COLS   = oled_text_pkg::COLS,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              refresh,
  output logic [7:0]        sdin,
  output logic              d_valid,
  input  logic              txDone,
  output logic              busy,
  output logic              frame_done
);

  localparam int NCELLS = LINES * COLS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NCELLS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              dirty;
  logic              refresh_pend;
  logic [7:0]        cell_data;
  logic              dirty_set;

  oled_char_ram #(
    .DEPTH  (NCELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .rd_addr   (idx),
    .rd_data   (cell_data),
    .dirty_set (dirty_set)
  );

  // Frame streamer: waits for a repaint reason, then walks every cell in
  // order through the controller handshake; new events arriving in the
  // start cycle survive so they trigger another frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      sdin         <= ASCII_SPACE;
      d_valid      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      dirty        <= 1'b1;
      refresh_pend <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      dirty        <= dirty | dirty_set;
      refresh_pend <= refresh_pend | refresh;
      case (state)
        IDLE: begin
          if (dirty || refresh_pend) begin
            state        <= LOAD;
            idx          <= '0;
            busy         <= 1'b1;
            dirty        <= dirty_set;
            refresh_pend <= refresh;
          end
        end
        LOAD: begin
          if (!txDone) begin
            sdin    <= cell_data;
            d_valid <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (txDone) begin
            d_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        FINISH: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_buffer.sv
// Self-checking bench for oled_text_buffer: a controller model acks each
// byte ten cycles after d_valid, captured frames are compared against a
// plain array model of the screen.
module tb_oled_text_buffer;

  localparam int N = 64;

  typedef logic [7:0] frame_t [N];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       refresh = 1'b0;
  logic       txDone = 1'b0;
  logic [7:0] sdin;
  logic       d_valid;
  logic       busy;
  logic       frame_done;

  frame_t ref_cells;
  frame_t cur;
  frame_t exp_a;
  frame_t frames [$];
  int     lens [$];
  int     frame_cnt = 0;
  int     cur_len = 0;
  int     wait_cnt = 0;
  int     checks = 0;
  int     passes = 0;

  oled_text_buffer #(
    .LINES  (4),
    .COLS   (16),
    .ADDR_W (7)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .refresh    (refresh),
    .sdin       (sdin),
    .d_valid    (d_valid),
    .txDone     (txDone),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // 100 MHz clock.
  initial forever #5 clock = ~clock;

  // Controller model and frame capture, both working on falling edges.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      txDone   = 1'b0;
      wait_cnt = 0;
      cur_len  = 0;
    end else begin
      if (txDone) begin
        txDone   = 1'b0;
        wait_cnt = 0;
      end else if (d_valid) begin
        wait_cnt++;
        if (wait_cnt == 10) begin
          txDone = 1'b1;
          if (cur_len < N) cur[cur_len] = sdin;
          cur_len++;
        end
      end
      if (frame_done) begin
        frames.push_back(cur);
        lens.push_back(cur_len);
        cur_len = 0;
        frame_cnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic checkFrame(input string tag, input int k, input frame_t exp);
    int mism = 0;
    int flen = -1;
    if (k >= 0 && k < frames.size()) begin
      flen = lens[k];
      for (int i = 0; i < N; i++) begin
        if (frames[k][i] !== exp[i]) mism++;
      end
    end else begin
      mism = N;
    end
    checkOutput({tag, "_bytes"}, mism, 0);
    checkOutput({tag, "_len"}, flen, N);
  endtask

  function automatic logic [7:0] getByte(input int k, input int i);
    if (k >= 0 && k < frames.size()) return frames[k][i];
    return 8'hxx;
  endfunction

  // Drive one cycle of inputs starting at a falling edge; keeps the model in step.
  task automatic applyStimulus(input logic we, input logic [6:0] a, input logic [7:0] c, input logic rf);
    wr_en   = we;
    wr_addr = a;
    wr_char = c;
    refresh = rf;
    if (we && a < 7'd64) ref_cells[a] = c;
    @(negedge clock);
  endtask

  task automatic clearInputs();
    wr_en   = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && frame_cnt < target; i++) @(negedge clock);
    checkOutput(tag, (frame_cnt >= target), 1);
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    int q = 0;
    for (int i = 0; i < budget && q < 30; i++) begin
      @(negedge clock);
      if (busy) q = 0;
      else q++;
    end
    checkOutput(tag, (q >= 30), 1);
  endtask

  task automatic waitSent(input string tag, input int count, input logic need_dv, input int budget);
    int i = 0;
    while (i < budget && !(cur_len >= count && (d_valid || !need_dv))) begin
      @(negedge clock);
      i++;
    end
    checkOutput(tag, (cur_len >= count), 1);
  endtask

  // Directed and randomized scenarios in sequence.
  initial begin
    int base;
    int n;
    logic seen;
    for (int i = 0; i < N; i++) ref_cells[i] = 8'h20;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_sdin", sdin, 8'h20);
    checkOutput("rst_dvalid", d_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fdone", frame_done, 1'b0);
    reset = 1'b0;

    waitFrames("first_frame", 1, 3000);
    checkFrame("blank", 0, ref_cells);
    waitQuiet("blank_quiet", 200);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clock);
      seen = seen | d_valid;
    end
    checkOutput("idle_dvalid", seen, 1'b0);
    checkOutput("idle_frames", frame_cnt, 1);

    base = frame_cnt;
    applyStimulus(1'b1, 7'd17, 8'h41, 1'b0);
    clearInputs();
    waitFrames("wr17_frame", base + 1, 3000);
    waitQuiet("wr17_quiet", 3000);
    checkOutput("wr17_count", frame_cnt, base + 1);
    checkFrame("wr17", base, ref_cells);
    checkOutput("wr17_b17", getByte(base, 17), 8'h41);

    base = frame_cnt;
    applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);
    clearInputs();
    waitSent("mid_reach", 30, 1'b0, 3000);
    exp_a = ref_cells;
    exp_a[40] = 8'h43;
    applyStimulus(1'b1, 7'd5, 8'h42, 1'b0);
    applyStimulus(1'b1, 7'd40, 8'h43, 1'b0);
    clearInputs();
    waitFrames("mid_frames", base + 2, 5000);
    waitQuiet("mid_quiet", 3000);
    checkOutput("mid_count", frame_cnt, base + 2);
    checkFrame("mid_cur", base, exp_a);
    checkFrame("mid_next", base + 1, ref_cells);
    checkOutput("mid_cur_b5", getByte(base, 5), 8'h20);
    checkOutput("mid_next_b5", getByte(base + 1, 5), 8'h42);

    base = frame_cnt;
    applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);
    clearInputs();
    waitFrames("refr_frame", base + 1, 3000);
    waitQuiet("refr_quiet", 3000);
    checkOutput("refr_count", frame_cnt, base + 1);
    checkFrame("refr", base, ref_cells);

    base = frame_cnt;
    applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);
    applyStimulus(1'b1, 7'd3, 8'h5A, 1'b1);
    clearInputs();
    waitFrames("both_frames", base + 2, 5000);
    waitQuiet("both_quiet", 3000);
    checkOutput("both_count", frame_cnt, base + 2);
    checkFrame("both_1", base, ref_cells);
    checkFrame("both_2", base + 1, ref_cells);

    base = frame_cnt;
    applyStimulus(1'b1, 7'd64, 8'h58, 1'b0);
    applyStimulus(1'b1, 7'd100, 8'h59, 1'b0);
    clearInputs();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | busy;
    end
    checkOutput("oor_busy", seen, 1'b0);
    checkOutput("oor_count", frame_cnt, base);
    applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);
    clearInputs();
    waitFrames("oor_frame", base + 1, 3000);
    checkFrame("oor", base, ref_cells);
    waitQuiet("oor_quiet", 3000);

    for (int r = 0; r < 3; r++) begin
      base = frame_cnt;
      n = int'($urandom_range(3, 8));
      for (int j = 0; j < n; j++) begin
        applyStimulus(1'b1, 7'($urandom_range(0, (j == 0) ? 63 : 80)),
                      8'($urandom_range(33, 126)), 1'b0);
      end
      clearInputs();
      waitQuiet("rnd_quiet", 8000);
      checkOutput("rnd_started", (frame_cnt > base), 1);
      checkFrame("rnd_last", frames.size() - 1, ref_cells);
    end

    applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);
    clearInputs();
    waitSent("rstmid_reach", 20, 1'b1, 3000);
    checkOutput("rstmid_dv_pre", d_valid, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rstmid_dvalid", d_valid, 1'b0);
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_sdin", sdin, 8'h20);
    for (int i = 0; i < N; i++) ref_cells[i] = 8'h20;
    @(negedge clock);
    reset = 1'b0;
    base = frame_cnt;
    waitFrames("rstmid_frame", base + 1, 3000);
    waitQuiet("rstmid_quiet", 3000);
    checkOutput("rstmid_count", frame_cnt, base + 1);
    checkFrame("rstmid_blank", base, ref_cells);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
